// File: rtl/serial_pkg.sv
// Shared types and constants for the serial link blocks.
// Line levels, FSM state encoding and the parity helper.
package serial_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

  localparam int MAX_W = 64;

  // Even parity bit: makes the total count of ones even.
  function automatic logic even_parity(
    input logic [MAX_W-1:0] v
  );
    return ^v;
  endfunction

endpackage

// File: rtl/serial_bit_timer.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1, pulses tc on the last.
// Shared by the transmitter and a future receiver.
import serial_pkg::*;

module serial_bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tc
);

  localparam int CW =
    (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count;

  assign tc = (count == LAST);

  // Free-running modulo counter, held at zero while cleared.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (tc) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/serial_tx.sv
// Start/data/stop serial transmitter with valid/ready input.
// Macros: SERIAL_TX_PARITY_EN (even parity bit), DUMP_ENABLED.
import serial_pkg::*;

module serial_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              tx,
  output logic              busy
);

  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  state_t            state;
  state_t            state_n;
  logic [DATA_W-1:0] shift;
  logic [DATA_W-1:0] shift_n;
  logic [BW-1:0]     bit_idx;
  logic [BW-1:0]     bit_n;
  logic              tx_n;
  logic              busy_n;
  logic              tc;
`ifdef SERIAL_TX_PARITY_EN
  logic              par;
  logic              par_n;
`endif

  serial_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clk  (clk),
    .reset(reset),
    .clear(state == IDLE),
    .tc   (tc)
  );

  assign in_ready = (state == IDLE);

  // Next state, shift/bit bookkeeping and the next line level.
  always_comb begin
    state_n = state;
    shift_n = shift;
    bit_n   = bit_idx;
    tx_n    = IDLE_LEVEL;
    busy_n  = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
    par_n   = par;
`endif
    unique case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          state_n = START;
          shift_n = in_data;
          bit_n   = '0;
`ifdef SERIAL_TX_PARITY_EN
          par_n   = even_parity(MAX_W'(in_data));
`endif
        end
      end
      START: begin
        if (tc) state_n = DATA;
      end
      DATA: begin
        if (tc) begin
          if (bit_idx == LAST_BIT) begin
`ifdef SERIAL_TX_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end else begin
            bit_n   = bit_idx + BW'(1);
            shift_n = shift >> 1;
          end
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      PARITY: begin
        if (tc) state_n = STOP;
      end
`endif
      STOP: begin
        if (tc) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    unique case (state_n)
      START:   tx_n = START_LEVEL;
      DATA:    tx_n = shift_n[0];
`ifdef SERIAL_TX_PARITY_EN
      PARITY:  tx_n = par_n;
`endif
      STOP:    tx_n = STOP_LEVEL;
      default: tx_n = IDLE_LEVEL;
    endcase
    busy_n = (state_n != IDLE);
  end

  // State, datapath and registered line outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      shift   <= '0;
      bit_idx <= '0;
      tx      <= IDLE_LEVEL;
      busy    <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      par     <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      shift   <= shift_n;
      bit_idx <= bit_n;
      tx      <= tx_n;
      busy    <= busy_n;
`ifdef SERIAL_TX_PARITY_EN
      par     <= par_n;
`endif
    end
  end

`ifdef DUMP_ENABLED
`endif

endmodule
